ela_stream_deinterlacer: RTL and testbench

// Parametrised edge-based line-average deinterlacer. Requests even rows from the host one at a time and

---
 rtl/ela_stream_deinterlacer.sv | 191 +++++++++++++++++++
 tb/tb_ela_stream_deinterlacer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ela_stream_deinterlacer.sv
// Edge-based line-average deinterlacer: streams even rows through to result memory and rebuilds
// each odd row from two ping-pong row buffers (line average, 3-direction ELA or line duplicate).
module ela_stream_deinterlacer #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  in_data,
  output logic              req,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data_wr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast     = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLastEven = RowW'(IMG_H - 2);
  localparam logic [RowW-1:0] RowLast     = RowW'(IMG_H - 1);

  typedef enum logic [2:0] {StIdle, StReq, StRecv, StInterp, StLast, StDone} state_e;

  state_e          state_q;
  logic [RowW-1:0] row_q;   // current even row (the lower buffer's row)
  logic [ColW-1:0] col_q;
  logic [1:0]      mode_q;
  logic            sel_q;   // which buffer holds the lower row; the other holds the upper row

  logic [PIX_W-1:0] lbuf [2][IMG_W];

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [RowW-1:0] r,
                                                 input logic [ColW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(IMG_W) + ADDR_W'(c);
  endfunction

  function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return PIX_W'(s >> 1);
  endfunction

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [ColW-1:0]  col_m1, col_p1;
  logic [PIX_W-1:0] u_m1, u_c, u_p1, d_m1, d_c, d_p1;
  logic [PIX_W-1:0] dif_1, dif_2, dif_3;
  logic [PIX_W-1:0] vert_pix, ela_pix, interp_pix;
  logic             edge_col;

  // Neighbour columns are clamped at the edges; those columns use the vertical average anyway.
  assign col_m1 = (col_q == '0) ? col_q : col_q - 1'b1;
  assign col_p1 = (col_q == ColLast) ? col_q : col_q + 1'b1;

  assign u_m1 = lbuf[~sel_q][col_m1];
  assign u_c  = lbuf[~sel_q][col_q];
  assign u_p1 = lbuf[~sel_q][col_p1];
  assign d_m1 = lbuf[sel_q][col_m1];
  assign d_c  = lbuf[sel_q][col_q];
  assign d_p1 = lbuf[sel_q][col_p1];

  always_comb begin
    dif_1    = absdiff(u_m1, d_p1);
    dif_2    = absdiff(u_c, d_c);
    dif_3    = absdiff(u_p1, d_m1);
    edge_col = (col_q == '0) || (col_q == ColLast);
    vert_pix = avg2(u_c, d_c);
    ela_pix  = vert_pix;
    // Tie priority: vertical, then D1, then D3.
    if (!((dif_2 <= dif_1) && (dif_2 <= dif_3))) begin
      ela_pix = (dif_1 <= dif_3) ? avg2(u_m1, d_p1) : avg2(u_p1, d_m1);
    end
    case (mode_q)
      2'd1:    interp_pix = edge_col ? vert_pix : ela_pix;
      2'd2:    interp_pix = u_c;
      default: interp_pix = vert_pix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && ready && (state_q == StRecv)) begin
      lbuf[sel_q][col_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 2'd0;
      sel_q   <= 1'b0;
      req     <= 1'b0;
      wen     <= 1'b0;
      addr    <= '0;
      data_wr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!ready) begin
      req <= 1'b0;
      wen <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          mode_q  <= mode;
          busy    <= 1'b1;
          row_q   <= '0;
          col_q   <= '0;
          req     <= 1'b1;
          wen     <= 1'b0;
          state_q <= StReq;
        end
        StReq: begin
          wen <= 1'b0;
          // A pulse lost to a ready drop is re-issued before receiving starts.
          if (req) begin
            req     <= 1'b0;
            col_q   <= '0;
            state_q <= StRecv;
          end else begin
            req <= 1'b1;
          end
        end
        StRecv: begin
          wen     <= 1'b1;
          addr    <= pix_addr(row_q, col_q);
          data_wr <= in_data;
          if (col_q == ColLast) begin
            col_q <= '0;
            if (row_q == '0) begin
              row_q   <= RowW'(2);
              sel_q   <= ~sel_q;
              req     <= 1'b1;
              state_q <= StReq;
            end else begin
              state_q <= StInterp;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StInterp: begin
          wen     <= 1'b1;
          addr    <= pix_addr(row_q - 1'b1, col_q);
          data_wr <= interp_pix;
          if (col_q == ColLast) begin
            col_q <= '0;
            sel_q <= ~sel_q;
            if (row_q == RowLastEven) begin
              state_q <= StLast;
            end else begin
              row_q   <= row_q + RowW'(2);
              req     <= 1'b1;
              state_q <= StReq;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StLast: begin
          wen     <= 1'b1;
          addr    <= pix_addr(RowLast, col_q);
          data_wr <= u_c;
          if (col_q == ColLast) begin
            col_q   <= '0;
            state_q <= StDone;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StDone: begin
          req  <= 1'b0;
          wen  <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ela_stream_deinterlacer.sv
// Bench for ela_stream_deinterlacer: host model streams even rows, a frame-level model predicts
// the whole output image and write order, and a compare process checks every write.
module tb_ela_stream_deinterlacer;
  localparam int W = 128;
  localparam int H = 64;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  in_data = 8'd0;
  logic        req, wen, busy, done;
  logic [12:0] addr;
  logic [7:0]  data_wr;

  always #5 clk = ~clk;

  ela_stream_deinterlacer #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8),
    .ADDR_W(13)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .mode   (mode),
    .in_data(in_data),
    .req    (req),
    .wen    (wen),
    .addr   (addr),
    .data_wr(data_wr),
    .busy   (busy),
    .done   (done)
  );

  logic [7:0] src [H][W];
  logic [7:0] exp_img [N];
  int         exp_order [N];
  int         wr_cnt [N];
  logic [7:0] mem [N];

  int   errors = 0;
  int   checks = 0;
  int   nwr = 0;
  int   req_pulses = 0;
  logic req_prev = 1'b0;
  logic rdy_edge = 1'b1;
  logic rst_edge = 1'b0;

  int host_row, host_k, drop_cnt;
  bit host_active, pending, drop1, drop2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int avg(input int a, input int b);
    return (a + b) / 2;
  endfunction

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Expected pixel of odd row o, column c, straight from the interpolation rules.
  function automatic int model_pix(input int m, input int o, input int c);
    int u, d, best, best_d;
    if (o == H - 1) return int'(src[H-2][c]);
    u = int'(src[o-1][c]);
    d = int'(src[o+1][c]);
    if (m == 2) return u;
    if (m == 1 && c > 0 && c < W - 1) begin
      best_d = adiff(u, d);
      best   = avg(u, d);
      if (adiff(int'(src[o-1][c-1]), int'(src[o+1][c+1])) < best_d) begin
        best_d = adiff(int'(src[o-1][c-1]), int'(src[o+1][c+1]));
        best   = avg(int'(src[o-1][c-1]), int'(src[o+1][c+1]));
      end
      if (adiff(int'(src[o-1][c+1]), int'(src[o+1][c-1])) < best_d) begin
        best = avg(int'(src[o-1][c+1]), int'(src[o+1][c-1]));
      end
      return best;
    end
    return avg(u, d);
  endfunction

  task automatic build_model(input int m);
    int rows[$];
    int n;
    rows.push_back(0);
    for (int r = 2; r <= H - 2; r += 2) begin
      rows.push_back(r);
      rows.push_back(r - 1);
    end
    rows.push_back(H - 1);
    n = 0;
    foreach (rows[i]) begin
      for (int c = 0; c < W; c++) begin
        exp_order[n] = rows[i] * W + c;
        n++;
      end
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_img[r*W+c] = (r % 2 == 0) ? src[r][c] : 8'(model_pix(m, r, c));
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) src[r][c] = 8'($urandom);
    end
  endtask

  always @(posedge clk) begin
    rdy_edge <= ready;
    rst_edge <= rst;
  end

  // Compare process: outputs are sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_edge) begin
      check("reset outputs", 32'({req, wen, addr, data_wr, busy, done}), 32'd0);
      nwr        = 0;
      req_pulses = 0;
      req_prev   = 1'b0;
      foreach (wr_cnt[i]) wr_cnt[i] = 0;
    end else begin
      if (req === 1'b1) begin
        check("req one cycle wide", 32'(req_prev), 32'd0);
        if (!req_prev) req_pulses++;
      end
      req_prev = (req === 1'b1);
      if (rdy_edge === 1'b0) check("no wen while ready low", 32'(wen), 32'd0);
      if (done === 1'b1 && wen === 1'b1) check("no wen when done", 32'(wen), 32'd0);
      if (wen === 1'b1) begin
        if (nwr >= N) begin
          check("write count overflow", nwr, N - 1);
        end else begin
          check("addr order", 32'(addr), exp_order[nwr]);
          check("write data", 32'(data_wr), 32'(exp_img[addr]));
          mem[addr] = data_wr;
          wr_cnt[addr]++;
          nwr++;
        end
      end
    end
  end

  task automatic run_frame(input logic [1:0] m, input int abort_at, input bit drops);
    bit fin;
    int bad;
    mode = m;
    build_model(int'(m));
    rst   = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    host_active = 0; pending = 0; host_row = 0; host_k = 0;
    drop_cnt = 0; drop1 = 0; drop2 = 0; fin = 0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (abort_at > 0 && nwr >= abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", 32'({req, wen, addr, data_wr, busy, done}), 32'd0);
        return;
      end
      if (drops && !drop1 && host_active && host_row == 4 && host_k == 60) begin
        drop1 = 1; drop_cnt = 3;
      end
      if (drops && !drop2 && nwr == 300) begin
        drop2 = 1; drop_cnt = 3;
      end
      ready = (drop_cnt == 0);
      if (drop_cnt > 0) drop_cnt--;
      if (pending) begin
        pending = 0; host_active = 1; host_k = 0;
      end
      in_data = (host_active && host_row < H) ? src[host_row][host_k] : 8'($urandom);
      if (req === 1'b1) pending = 1;
      @(posedge clk);
      #1;
      if (host_active && ready) begin
        host_k++;
        if (host_k == W) begin
          host_active = 0;
          host_row += 2;
        end
      end
      if (done === 1'b1) fin = 1;
    end
    check("frame finished in time", 32'(fin), 32'd1);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done held", 32'(done), 32'd1);
    check("busy low after done", 32'(busy), 32'd0);
    check("total writes", nwr, N);
    check("req pulses", req_pulses, H / 2);
    bad = 0;
    foreach (wr_cnt[i]) if (wr_cnt[i] != 1) bad++;
    check("each addr written once", bad, 0);
  endtask

  initial begin
    // Mode 0: flat rows give hand-checkable averages and last-row duplication.
    fill_random();
    for (int c = 0; c < W; c++) begin
      src[0][c]  = 8'd10;
      src[2][c]  = 8'd21;
      src[62][c] = 8'd33;
    end
    run_frame(2'd0, 0, 1'b0);
    check("m0 model row1 floor", 32'(exp_img[W+7]), 32'd15);
    check("m0 row1 floor avg", 32'(mem[W+5]), 32'd15);
    check("m0 row0 passthrough", 32'(mem[4]), 32'd10);
    check("m0 row2 passthrough", 32'(mem[2*W+3]), 32'd21);
    check("m0 last row dup", 32'(mem[63*W+9]), 32'd33);

    // Mode 1: diagonal, edge and tie patterns.
    fill_random();
    src[0][0] = 8'd0;   src[0][1] = 8'd10;  src[0][2] = 8'd200;
    src[2][0] = 8'd200; src[2][1] = 8'd120; src[2][2] = 8'd5;
    src[8][0] = 8'd100; src[8][1] = 8'd0;   src[10][0] = 8'd0;  src[10][1] = 8'd200;
    src[8][W-1] = 8'd240; src[8][W-2] = 8'd0; src[10][W-1] = 8'd0; src[10][W-2] = 8'd240;
    src[12][4] = 8'd10;  src[12][5] = 8'd50; src[12][6] = 8'd90;
    src[14][4] = 8'd110; src[14][5] = 8'd70; src[14][6] = 8'd30;
    src[12][19] = 8'd10;  src[12][20] = 8'd0;   src[12][21] = 8'd90;
    src[14][19] = 8'd110; src[14][20] = 8'd200; src[14][21] = 8'd30;
    run_frame(2'd1, 0, 1'b0);
    check("m1 model diagonal", 32'(exp_img[W+1]), 32'd200);
    check("m1 diagonal D3", 32'(mem[W+1]), 32'd200);
    check("m1 left edge vertical", 32'(mem[9*W]), 32'd50);
    check("m1 right edge vertical", 32'(mem[9*W+W-1]), 32'd120);
    check("m1 all-tie vertical", 32'(mem[13*W+5]), 32'd60);
    check("m1 D1 beats D3 tie", 32'(mem[13*W+20]), 32'd20);

    // Mode 2: line duplicate.
    fill_random();
    src[0][3]  = 8'd77;
    src[62][0] = 8'd5;
    run_frame(2'd2, 0, 1'b0);
    check("m2 duplicate upper", 32'(mem[W+3]), 32'd77);
    check("m2 last row dup", 32'(mem[63*W]), 32'd5);

    // Mode 3 behaves as mode 0; ready dropped mid-RECV and mid-INTERP.
    fill_random();
    src[0][0] = 8'd1;
    src[2][0] = 8'd4;
    run_frame(2'd3, 0, 1'b1);
    check("m3 acts as avg", 32'(mem[W]), 32'd2);

    // Reset mid-INTERP of row 3, then a fresh frame from row 0.
    fill_random();
    run_frame(2'd1, 560, 1'b0);
    fill_random();
    src[0][0] = 8'd0;   src[0][1] = 8'd10;  src[0][2] = 8'd200;
    src[2][0] = 8'd200; src[2][1] = 8'd120; src[2][2] = 8'd5;
    run_frame(2'd1, 0, 1'b0);
    check("after abort diagonal", 32'(mem[W+1]), 32'd200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
